// File: rtl/countdown_timer.sv
// countdown_timer: loadable prescaled down-counter that pulses done on expiry
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset
//   load       - capture load_value into count and reload register, go IDLE
//   load_value - value captured on load
//   start      - begin counting from IDLE, or resume from PAUSE
//   pause      - suspend counting while in RUN
//   count      - current count (registered)
//   busy       - high in RUN or PAUSE
//   zero       - count equals zero
//   done       - one-cycle pulse in the cycle after an expiry tick (registered)
module countdown_timer #(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 1,
    parameter bit AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             zero,
    output logic             done
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    logic [1:0]       state;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] reload;
    logic             tick;
    logic             go;
    assign tick = presc == PMAX;
    assign go   = start && !pause;
    assign busy = state != IDLE;
    assign zero = count == '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            presc  <= '0;
            done   <= 1'b0;
        end else if (load) begin
            state  <= IDLE;
            count  <= load_value;
            reload <= load_value;
            presc  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && !zero) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state <= PAUSE;
                    end else if (!tick) begin
                        presc <= presc + PW'(1);
                    end else begin
                        presc <= '0;
                        // count==1 on a tick is expiry; reload skips the zero value entirely
                        if (count == WIDTH'(1)) begin
                            done  <= 1'b1;
                            count <= AUTO_RELOAD ? reload : '0;
                            state <= AUTO_RELOAD ? RUN : IDLE;
                        end else if (!zero) begin
                            count <= count - WIDTH'(1);
                        end
                    end
                end
                PAUSE: state <= go ? RUN : PAUSE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: four parameter variants of countdown_timer against a behavioural model
module tb_countdown_timer;
    localparam int N = 4;
    localparam int P[N]  = '{1, 4, 1, 3};
    localparam int AR[N] = '{0, 0, 1, 1};
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] cnt [N];
    logic       busy [N];
    logic       zero [N];
    logic       done [N];
    int         errors = 0;
    int         checks = 0;
    int         m_cnt [N];
    int         m_rel [N];
    int         m_ph [N];
    int         m_st [N];
    int         m_done [N];

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(0)) d0 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
        .count(cnt[0]), .busy(busy[0]), .zero(zero[0]), .done(done[0]));
    countdown_timer #(.WIDTH(8), .PRESCALE(4), .AUTO_RELOAD(0)) d1 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
        .count(cnt[1]), .busy(busy[1]), .zero(zero[1]), .done(done[1]));
    countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(1)) d2 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
        .count(cnt[2]), .busy(busy[2]), .zero(zero[2]), .done(done[2]));
    countdown_timer #(.WIDTH(8), .PRESCALE(3), .AUTO_RELOAD(1)) d3 (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value), .start(start), .pause(pause),
        .count(cnt[3]), .busy(busy[3]), .zero(zero[3]), .done(done[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0; m_rel[k] = 0; m_ph[k] = 0; m_st[k] = 0; m_done[k] = 0;
        end
    endtask

    // mode 0 = idle, 1 = running, 2 = paused; m_ph counts running cycles since the last decrement
    task automatic model_step(input bit ld, input int lv, input bit st, input bit ps);
        for (int k = 0; k < N; k++) begin
            m_done[k] = 0;
            if (ld) begin
                m_cnt[k] = lv; m_rel[k] = lv; m_ph[k] = 0; m_st[k] = 0;
            end else if (m_st[k] == 0) begin
                if (st && !ps && m_cnt[k] != 0) begin m_st[k] = 1; m_ph[k] = 0; end
            end else if (m_st[k] == 2) begin
                if (st && !ps) m_st[k] = 1;
            end else if (ps) begin
                m_st[k] = 2;
            end else begin
                m_ph[k]++;
                if (m_ph[k] == P[k]) begin
                    m_ph[k] = 0;
                    if (m_cnt[k] == 1) begin
                        m_done[k] = 1;
                        if (AR[k] != 0) m_cnt[k] = m_rel[k];
                        else begin m_cnt[k] = 0; m_st[k] = 0; end
                    end else begin
                        m_cnt[k]--;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("count%0d", k), 32'(cnt[k]), 32'(m_cnt[k] & 255));
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_st[k] != 0));
            chk($sformatf("zero%0d", k), 32'(zero[k]), 32'(m_cnt[k] == 0));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
        end
    endtask

    task automatic cyc(input bit ld, input int lv, input bit st, input bit ps);
        load = ld; load_value = 8'(lv); start = st; pause = ps;
        @(posedge clk);
        model_step(ld, lv, st, ps);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        chk("reset_zero", 32'(zero[0]), 32'd1);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check_all();

        // defaults: 4,3,2,1,0 with done alongside 0; prescale 4: done 12 cycles after start
        cyc(1, 5, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 14; i++) begin
            cyc(0, 0, 0, 0);
            if (i <= 5) chk("t1_count", 32'(cnt[0]), 32'(5 - i));
            if (i <= 5) chk("t1_done", 32'(done[0]), 32'(i == 5));
        end
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 14; i++) begin
            cyc(0, 0, 0, 0);
            chk("t2_count", 32'(cnt[1]), 32'(i < 12 ? 3 - i / 4 : 0));
            chk("t2_done", 32'(done[1]), 32'(i == 12));
        end

        // pause/resume with no lost or extra steps
        cyc(1, 10, 0, 0);
        cyc(0, 0, 1, 0);
        idle(3);
        chk("t3_run3", 32'(cnt[0]), 32'd7);
        cyc(0, 0, 0, 1);
        idle(4);
        chk("t3_hold", 32'(cnt[0]), 32'd7);
        chk("t3_busy", 32'(busy[0]), 32'd1);
        cyc(0, 0, 1, 1);
        chk("t3_both", 32'(cnt[0]), 32'd7);
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0, 0);
            chk("t3_count", 32'(cnt[0]), 32'(i < 7 ? 7 - i : 0));
            chk("t3_done", 32'(done[0]), 32'(i == 7));
        end

        // auto reload: 2,1,3,2,1,3,... never zero
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0, 0);
            chk("t4_count", 32'(cnt[2]), 32'(3 - (i % 3)));
            chk("t4_done", 32'(done[2]), 32'(i % 3 == 0));
        end

        // edge cases: start on zero, simultaneous load/start/pause, start+pause in IDLE
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("t5_zero_start", 32'(busy[0]), 32'd0);
        cyc(1, 6, 0, 0);
        cyc(0, 0, 1, 0);
        idle(2);
        chk("t5_at4", 32'(cnt[0]), 32'd4);
        cyc(1, 9, 1, 1);
        chk("t5_load_cnt", 32'(cnt[0]), 32'd9);
        chk("t5_load_busy", 32'(busy[0]), 32'd0);
        cyc(0, 0, 1, 1);
        chk("t5_sp_idle", 32'(busy[0]), 32'd0);

        // async reset mid-run
        cyc(1, 200, 0, 0);
        cyc(0, 0, 1, 0);
        idle(10);
        chk("t6_at190", 32'(cnt[0]), 32'd190);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b1;
        idle(3);
        cyc(0, 0, 1, 0);
        idle(2);
        chk("t6_start_ign", 32'(busy[0]), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 15) == 0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9),
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
